// File: rtl/multi_stepper_ctrl.sv
// N-channel stepper-motor controller: each channel runs a commanded number of
// coil steps, one per shared prescaler tick, then pulses done.
module multi_stepper_ctrl #(
   parameter int N_CH      = 3,
   parameter int CNT_W     = 16,
   parameter int DIV       = 524288,
   parameter int HALF_STEP = 0,
   parameter int HOLD      = 1,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [CH_W-1:0]     cmd_ch,
   input  logic                cmd_dir,
   input  logic [CNT_W-1:0]    cmd_steps,
   input  logic [N_CH-1:0]     stop,
   output logic [4*N_CH-1:0]   signal,
   output logic [N_CH-1:0]     busy,
   output logic [N_CH-1:0]     done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic [PW-1:0]    presc;
   logic             tick;
   logic             accept;
   logic             ch_ok;
   logic             busy_sel;
   logic             stop_sel;
   logic [2:0]       idx       [N_CH];
   logic [2:0]       step_idx  [N_CH];
   logic [CNT_W-1:0] remaining [N_CH];
   logic             dir_q     [N_CH];

   function automatic logic [3:0] coil_pattern(input logic [2:0] i);
      logic [3:0] p;
      if (HALF_STEP != 0) begin
         case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1100;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0010;
            3'd5:    p = 4'b0011;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
         endcase
      end else begin
         case (i)
            3'd0:    p = 4'b1100;
            3'd1:    p = 4'b0110;
            3'd2:    p = 4'b0011;
            default: p = 4'b1001;
         endcase
      end
      return p;
   endfunction

   assign tick   = (presc == PRESC_LAST);
   assign accept = cmd_valid & cmd_ready;

   // Out-of-range channel numbers select nothing, so they can never be accepted.
   always_comb begin
      ch_ok    = (int'(cmd_ch) < N_CH);
      busy_sel = 1'b0;
      stop_sel = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(cmd_ch) == k) begin
            busy_sel = busy[k];
            stop_sel = stop[k];
         end
      end
      cmd_ready = rst & ch_ok & ~busy_sel & ~stop_sel;
   end

   // Full-step mode keeps the index in 0..3 by clearing the top bit.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         step_idx[k] = dir_q[k] ? idx[k] + 3'd1 : idx[k] - 3'd1;
         if (HALF_STEP == 0) begin
            step_idx[k][2] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc  <= '0;
         busy   <= '0;
         done   <= '0;
         signal <= '0;
         for (int k = 0; k < N_CH; k++) begin
            idx[k]       <= '0;
            remaining[k] <= '0;
            dir_q[k]     <= 1'b0;
         end
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         for (int k = 0; k < N_CH; k++) begin
            done[k] <= 1'b0;
            // Stop wins over a coincident tick and never produces a done pulse.
            if (stop[k]) begin
               busy[k]      <= 1'b0;
               remaining[k] <= '0;
               if (HOLD == 0) begin
                  signal[4*k +: 4] <= 4'b0000;
               end
            end else if (busy[k]) begin
               if (tick) begin
                  idx[k]       <= step_idx[k];
                  remaining[k] <= remaining[k] - CNT_W'(1);
                  if (remaining[k] == CNT_W'(1)) begin
                     busy[k]          <= 1'b0;
                     done[k]          <= 1'b1;
                     signal[4*k +: 4] <= (HOLD != 0) ? coil_pattern(step_idx[k]) : 4'b0000;
                  end else begin
                     signal[4*k +: 4] <= coil_pattern(step_idx[k]);
                  end
               end
            end else if (accept && (int'(cmd_ch) == k)) begin
               if (cmd_steps == '0) begin
                  done[k] <= 1'b1;
               end else begin
                  busy[k]      <= 1'b1;
                  remaining[k] <= cmd_steps;
                  dir_q[k]     <= cmd_dir;
               end
            end
         end
      end
   end

endmodule

// File: doc/multi_stepper_ctrl.md
Name: multi_stepper_ctrl

Overview:
- Parametrised N-channel stepper-motor controller.
- Each channel accepts a move command: direction plus step count. It steps its 4-bit coil output once per shared step tick until the count is exhausted, then pulses done.
- Supports full-step or half-step drive and optional holding torque. Per-channel abort is provided.
- Sits between the switch/command logic and the motor driver pins. It replaces free-running per-motor drivers fed by an external clock divider.

Parameters:
- N_CH, 3, number of motor channels (1..8).
- CNT_W, 16, width of step-count field.
- DIV, 524288, clk cycles per step tick (>=2).
- HALF_STEP, 0, 0 = 4-entry full-step sequence, 1 = 8-entry half-step sequence.
- HOLD, 1, 1 = keep last coil pattern when idle, 0 = drive 4'b0000 when idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_ch  in  $clog2(N_CH) (min 1)  target channel.
- cmd_dir  in  1  1 = forward (phase index increments), 0 = reverse.
- cmd_steps  in  CNT_W  number of steps to move.
- stop  in  N_CH  per-channel abort, level-sampled.
- signal  out  4*N_CH  coil patterns; channel k occupies bits [4k+3:4k].
- busy  out  N_CH  channel moving.
- done  out  N_CH  one-cycle pulse when a move completes normally.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst==0 at a clk edge):
  - prescaler=0; all phase indices=0; remaining counts=0.
  - busy=0, done=0, signal=all 0.
  - cmd_ready follows the combinational rule below.
  - Reset mid-move aborts the move with no done pulse.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick=1 for exactly the cycle in which the count equals DIV-1.
  - Free-runs regardless of channel activity; shared by all channels.
- cmd_ready is combinational:
  - cmd_ready = rst & ~busy[cmd_ch] & ~stop[cmd_ch] & (cmd_ch < N_CH).
  - Out-of-range cmd_ch is never accepted.
- Accept happens on a cycle with cmd_valid & cmd_ready:
  - cmd_steps==0: no motion; done[cmd_ch] pulses the next cycle; busy stays 0.
  - Otherwise: busy[ch]=1 from the next cycle; remaining=cmd_steps; dir latched.
- Each busy channel, on every tick:
  - Phase index moves ±1 modulo 4 (full-step) or modulo 8 (half-step).
  - signal[ch] updates in the same registered edge.
  - remaining decrements by 1.
  - When remaining goes 1->0: busy drops and done pulses, both effective the cycle after that tick.
- A tick coinciding with the accept cycle does not step the new move. The first step is on the next tick after busy rises.
- Sequences, listed by index:
  - Full-step: 1100, 0110, 0011, 1001.
  - Half-step: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Idle coil output:
  - HOLD=1: idle channel outputs the pattern at its current index. Exception: after reset, outputs 0000 until its first move.
  - HOLD=0: idle channel outputs 0000.
  - In both cases the phase index is retained across moves.
- stop[k]=1 at an edge:
  - busy[k]=0 and remaining=0 the next cycle; no done pulse; the index is kept.
  - stop has priority over a same-cycle tick; no step occurs on that tick.
  - stop[k] high also blocks accept for channel k (cmd_ready=0).
- Channels are independent and may complete on the same tick. Multiple done bits may pulse together.
- Max move is 2^CNT_W-1 steps; there is no wrap of remaining.

Test Plan:
- Full-step move: DIV=4, HALF_STEP=0. Reset, then accept ch0 dir=1 steps=5.
  - cmd_ready=1 on the accept cycle; busy[0]=1 for exactly 5 ticks.
  - signal[3:0] = 0110, 0011, 1001, 1100, 0110.
  - done[0] pulses once; signal holds 0110 afterwards (HOLD=1).
- Reverse half-step: HALF_STEP=1. Reverse move steps=3 from index 0.
  - signal = 1001, 0001, 0011; busy drops with a single done pulse.
- Busy rejection and parallel completion:
  - While ch1 is busy, present a command to ch1 -> cmd_ready=0 and nothing changes.
  - Present a command to ch2 the same cycle -> accepted.
  - Both finish when due, with independent done pulses; equal-length moves started the same tick give simultaneous done.
- Zero-step move: steps=0 to ch0 -> done[0] pulses the cycle after accept; busy[0] never rises; signal unchanged.
- Abort mid-move: assert stop[0] for one cycle during a 10-step move after 3 ticks.
  - busy[0]=0 next cycle; no done; signal frozen at step-3 pattern (HOLD=1) or 0000 (HOLD=0).
  - A new command is accepted once stop is low.
- Reset mid-move: drive rst=0 for one cycle during an active move.
  - All outputs 0 next cycle; no done.
  - Prescaler restarts, so the first tick after a new accept is DIV cycles after reset release.
